// File: rtl/sincos_cordic_engine_if.sv
// Handshake and data bundle for the sine/cosine CORDIC engine.
// The master side (controller) drives start/ack and the angle; the slave side returns results.
interface sincos_cordic_engine_if #(
  parameter int W = 32
);
  logic                beg_fsm_cordic;
  logic                ack_cordic;
  logic                operation;
  logic signed [W-1:0] data_in;
  logic [1:0]          shift_region_flag;
  logic                ready_cordic;
  logic signed [W-1:0] sin_out;
  logic signed [W-1:0] cos_out;
  logic signed [W-1:0] data_output;
  logic                range_flag;

  modport master (
    output beg_fsm_cordic, ack_cordic, operation, data_in, shift_region_flag,
    input  ready_cordic, sin_out, cos_out, data_output, range_flag
  );

  modport slave (
    input  beg_fsm_cordic, ack_cordic, operation, data_in, shift_region_flag,
    output ready_cordic, sin_out, cos_out, data_output, range_flag
  );
endinterface

// File: rtl/sincos_cordic_engine.sv
// Iterative rotation-mode CORDIC producing sin and cos of a Q2.(W-2) angle with quadrant fold-back.
// Optional macro SINCOS_GAIN_COMP_EN pre-scales the start vector by 1/K so outputs are true sin/cos.
module sincos_cordic_engine #(
  parameter int W    = 32,
  parameter int ITER = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  sincos_cordic_engine_if.slave  bus
);
  localparam int XW = W + 2;
  localparam int CW = $clog2(ITER);

  typedef logic signed [XW-1:0] xw_t;
  typedef enum logic [1:0] {IDLE, ROT, FIXUP, DONE} state_t;

  function automatic xw_t atan_fn(input int i);
    real a;
    a = $atan(1.0 / (2.0 ** i)) * (2.0 ** (W - 2));
    return xw_t'($rtoi(a + 0.5));
  endfunction

  function automatic xw_t x0_fn();
`ifdef SINCOS_GAIN_COMP_EN
    real k;
    k = 1.0;
    for (int i = 0; i < ITER; i++) k = k * $sqrt(1.0 + 1.0 / (2.0 ** (2 * i)));
    return xw_t'($rtoi((2.0 ** (W - 2)) / k + 0.5));
`else
    return {4'b0001, {(W-2){1'b0}}};
`endif
  endfunction

  function automatic logic [W-1:0] half_pi_fn();
    real a;
    a = 2.0 * $atan(1.0) * (2.0 ** (W - 2));
    return W'($rtoi(a + 0.5));
  endfunction

  localparam xw_t           X0      = x0_fn();
  localparam logic [W-1:0]  HALF_PI = half_pi_fn();
  localparam xw_t           SAT_HI  = {3'b000, {(W-1){1'b1}}};
  localparam xw_t           SAT_LO  = {3'b111, {(W-1){1'b0}}};

  function automatic logic signed [W-1:0] sat(input xw_t v);
    if (v > SAT_HI)      return SAT_HI[W-1:0];
    else if (v < SAT_LO) return SAT_LO[W-1:0];
    else                 return v[W-1:0];
  endfunction

  xw_t atan_tab [ITER];
  for (genvar gi = 0; gi < ITER; gi++) begin : g_atan
    localparam xw_t ATAN_I = atan_fn(gi);
    assign atan_tab[gi] = ATAN_I;
  end

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  xw_t                 x_q, y_q, z_q;
  xw_t                 x_d, y_d, z_d;
  logic                op_q;
  logic [1:0]          flag_q;
  logic signed [W-1:0] sin_q, cos_q, dout_q;
  logic signed [W-1:0] sin_d, cos_d;
  logic                ready_q, range_q;
  xw_t                 x_sh, y_sh;
  logic [W-1:0]        abs_in;
  logic                out_range;

  always_comb begin
    x_sh = x_q >>> cnt_q;
    y_sh = y_q >>> cnt_q;
    if (!z_q[XW-1]) begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_tab[cnt_q];
    end else begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_tab[cnt_q];
    end
    // Fold the caller-removed quadrant back onto the first-quadrant rotation result.
    case (flag_q)
      2'b00:   begin sin_d = sat(x_q == x_q ? y_q : y_q); cos_d = sat(x_q);  end
      2'b01:   begin sin_d = sat(x_q);  cos_d = sat(-y_q); end
      2'b10:   begin sin_d = sat(-y_q); cos_d = sat(-x_q); end
      default: begin sin_d = sat(-x_q); cos_d = sat(y_q);  end
    endcase
    abs_in    = bus.data_in[W-1] ? unsigned'(-bus.data_in) : unsigned'(bus.data_in);
    out_range = abs_in > HALF_PI;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      op_q    <= 1'b0;
      flag_q  <= 2'b00;
      sin_q   <= '0;
      cos_q   <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      range_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.beg_fsm_cordic) begin
          x_q     <= X0;
          y_q     <= '0;
          z_q     <= xw_t'(bus.data_in);
          cnt_q   <= '0;
          op_q    <= bus.operation;
          flag_q  <= bus.shift_region_flag;
          range_q <= out_range;
          state_q <= ROT;
        end
        ROT: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) state_q <= FIXUP;
        end
        FIXUP: begin
          sin_q   <= sin_d;
          cos_q   <= cos_d;
          dout_q  <= op_q ? sin_d : cos_d;
          ready_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (bus.ack_cordic) begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready_cordic = ready_q;
  assign bus.sin_out      = sin_q;
  assign bus.cos_out      = cos_q;
  assign bus.data_output  = dout_q;
  assign bus.range_flag   = range_q;
endmodule

// File: tb/tb_sincos_cordic_engine.sv
// Directed bench for sincos_cordic_engine at W=16, ITER=14; expectations follow SINCOS_GAIN_COMP_EN.
module tb_sincos_cordic_engine;
  localparam int W    = 16;
  localparam int ITER = 14;
`ifdef SINCOS_GAIN_COMP_EN
  localparam real GAIN = 1.0;
  localparam int  TOL  = 4;
`else
  localparam real GAIN = 1.6467602;
  localparam int  TOL  = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sincos_cordic_engine_if #(.W(W)) bus ();
  sincos_cordic_engine #(.W(W), .ITER(ITER)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  int n;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp);
    logic ok;
    checks++;
    ok = (obs >= exp - TOL) && (obs <= exp + TOL);
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, TOL);
    end
  endtask

  function automatic int sc(input int v);
    real r;
    r = v * GAIN;
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int ang, input logic [1:0] fl, input logic op);
    bus.data_in           = 16'(ang);
    bus.shift_region_flag = fl;
    bus.operation         = op;
    bus.beg_fsm_cordic    = 1'b1;
    tick();
    bus.beg_fsm_cordic    = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (bus.ready_cordic !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_ack();
    bus.ack_cordic = 1'b1;
    tick();
    bus.ack_cordic = 1'b0;
  endtask

  task automatic run(input string tag, input int ang, input logic [1:0] fl, input logic op,
                     input int es, input int ec);
    int cyc;
    start(ang, fl, op);
    wait_ready(cyc);
    chk({tag, "_latency"}, cyc, ITER + 1);
    chk_near({tag, "_sin"}, bus.sin_out, sc(es));
    chk_near({tag, "_cos"}, bus.cos_out, sc(ec));
    chk_near({tag, "_dout"}, bus.data_output, op ? sc(es) : sc(ec));
    do_ack();
    chk({tag, "_ready_clr"}, bus.ready_cordic, 0);
  endtask

  initial begin
    bus.beg_fsm_cordic    = 1'b0;
    bus.ack_cordic        = 1'b0;
    bus.operation         = 1'b0;
    bus.data_in           = '0;
    bus.shift_region_flag = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ready", bus.ready_cordic, 0);
    chk("rst_sin", bus.sin_out, 0);
    chk("rst_cos", bus.cos_out, 0);
    chk("rst_dout", bus.data_output, 0);
    chk("rst_range", bus.range_flag, 0);

    run("zero", 0, 2'b00, 1'b1, 0, 16384);
    chk("zero_range", bus.range_flag, 0);
    run("pi4", 12868, 2'b00, 1'b0, 11585, 11585);

    // -pi/4 with ack held across the rotation phase.
    start(-12868, 2'b00, 1'b0);
    bus.ack_cordic = 1'b1;
    repeat (10) tick();
    bus.ack_cordic = 1'b0;
    wait_ready(n);
    chk("ackrot_latency", n, ITER + 1 - 10);
    chk_near("npi4_sin", bus.sin_out, sc(-11585));
    chk_near("npi4_cos", bus.cos_out, sc(11585));
    chk_near("npi4_dout", bus.data_output, sc(11585));
    repeat (3) tick();
    chk("ready_held", bus.ready_cordic, 1);

    // beg together with ack in DONE: only the ack is honoured.
    bus.data_in        = 16'sd8579;
    bus.beg_fsm_cordic = 1'b1;
    bus.ack_cordic     = 1'b1;
    tick();
    bus.beg_fsm_cordic = 1'b0;
    bus.ack_cordic     = 1'b0;
    chk("begack_ready", bus.ready_cordic, 0);
    repeat (20) tick();
    chk("begack_norestart", bus.ready_cordic, 0);
    chk_near("begack_hold_sin", bus.sin_out, sc(-11585));

    start(8579, 2'b01, 1'b1);
    repeat (5) tick();
    chk_near("midrun_hold_sin", bus.sin_out, sc(-11585));
    wait_ready(n);
    chk("q1_latency", n, ITER + 1 - 5);
    chk_near("q1_sin", bus.sin_out, sc(14189));
    chk_near("q1_cos", bus.cos_out, sc(-8192));
    chk_near("q1_dout", bus.data_output, sc(14189));
    do_ack();
    run("q2", 8579, 2'b10, 1'b0, -8192, -14189);
    run("q3", 8579, 2'b11, 1'b1, -14189, 8192);

    start(29491, 2'b00, 1'b1);
    chk("range_set", bus.range_flag, 1);
    wait_ready(n);
    chk("range_latency", n, ITER + 1);
    do_ack();
    start(0, 2'b00, 1'b0);
    chk("range_clr", bus.range_flag, 0);
    wait_ready(n);
    chk_near("range_zero_cos", bus.cos_out, sc(16384));
    chk_near("range_zero_dout", bus.data_output, sc(16384));
    do_ack();

    // Reset pulse mid-rotation after an out-of-range start.
    start(29491, 2'b00, 1'b1);
    chk("rstmid_range_pre", bus.range_flag, 1);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_ready", bus.ready_cordic, 0);
    chk("rstmid_sin", bus.sin_out, 0);
    chk("rstmid_cos", bus.cos_out, 0);
    chk("rstmid_dout", bus.data_output, 0);
    chk("rstmid_range", bus.range_flag, 0);
    repeat (20) tick();
    chk("rstmid_idle", bus.ready_cordic, 0);
    run("post_rst_pi4", 12868, 2'b00, 1'b1, 11585, 11585);

    // beg asserted during ROT must not restart or change the operands.
    start(12868, 2'b00, 1'b1);
    bus.data_in           = '0;
    bus.shift_region_flag = 2'b10;
    bus.operation         = 1'b0;
    bus.beg_fsm_cordic    = 1'b1;
    repeat (3) tick();
    bus.beg_fsm_cordic    = 1'b0;
    wait_ready(n);
    chk("begrot_latency", n, ITER + 1 - 3);
    chk_near("begrot_sin", bus.sin_out, sc(11585));
    chk_near("begrot_cos", bus.cos_out, sc(11585));
    chk_near("begrot_dout", bus.data_output, sc(11585));
    do_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
